// File: rtl/mult_stream_pkg.sv
// Shared types and helpers for the streaming multiplier: FSM state, width helpers
// and the operand extension rule used for signed/unsigned beats.
package mult_stream_pkg;

  typedef enum logic {INIT, RUN} state_t;

  function automatic int prod_width(input int n);
    return 2 * n;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Extra top bit of the (N+1)-bit operand: the sign copy for signed beats, zero otherwise.
  function automatic logic ext_op(input logic op_msb, input logic sgn);
    return sgn & op_msb;
  endfunction

endpackage

// File: rtl/mult_core.sv
// Combinational (N+1)x(N+1) two's-complement multiplier: radix-4 modified Booth rows
// reduced through a carry-save array, low 2N bits of the product returned.
module mult_core #(
  parameter int N = 16
) (
  input  logic [N:0]     a,
  input  logic [N:0]     b,
  output logic [2*N-1:0] p
);

  localparam int W  = N + 1;
  localparam int PW = 2 * N;
  localparam int G  = (W + 1) / 2;
  localparam int R  = G + 1;
  localparam int BW = 2 * G + 1;

  logic [PW-1:0] a_sx;
  logic [BW-1:0] b_x;
  logic [PW-1:0] rows [R];
  logic [PW-1:0] csa_s;
  logic [PW-1:0] csa_c;

  assign a_sx = PW'($signed(a));
  // Bit 0 is the implicit b[-1]=0 of the first Booth group; top bits sign-extend b.
  assign b_x  = BW'($signed({b, 1'b0}));

  // Negative digits use one's complement plus a +1 collected in the final row.
  always_comb begin : booth_rows
    logic          neg;
    logic          one;
    logic          two;
    logic [PW-1:0] mag;
    logic [PW-1:0] corr;
    neg  = 1'b0;
    one  = 1'b0;
    two  = 1'b0;
    mag  = '0;
    corr = '0;
    for (int i = 0; i < G; i++) begin
      neg = b_x[2*i+2];
      one = b_x[2*i+1] ^ b_x[2*i];
      two = (b_x[2*i+2] & ~b_x[2*i+1] & ~b_x[2*i]) |
            (~b_x[2*i+2] & b_x[2*i+1] & b_x[2*i]);
      mag = one ? a_sx : (two ? (a_sx << 1) : '0);
      rows[i] = (neg ? ~mag : mag) << (2 * i);
      corr[2*i] = neg;
    end
    rows[G] = corr;
  end

  always_comb begin : csa_reduce
    logic [PW-1:0] t;
    t     = '0;
    csa_s = rows[0];
    csa_c = rows[1];
    for (int i = 2; i < R; i++) begin
      t     = csa_s ^ csa_c ^ rows[i];
      csa_c = ((csa_s & csa_c) | (csa_s & rows[i]) | (csa_c & rows[i])) << 1;
      csa_s = t;
    end
  end

  assign p = csa_s + csa_c;

endmodule

// File: rtl/mult_stream_pipe.sv
// Streaming pipelined multiplier: credit-gated input, LAT-1 stages after the core,
// and an output FIFO sized so downstream backpressure never stalls the pipeline.
module mult_stream_pipe
  import mult_stream_pkg::*;
#(
  parameter int N     = 16,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_a,
  input  logic [N-1:0]           in_b,
  input  logic                   in_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N-1:0]         out_data,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int PW = prod_width(N);
  localparam int CW = cnt_width(DEPTH);
  localparam int AW = $clog2(DEPTH);

  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] last_q, last_d;
  logic [PW-1:0] mem_q [DEPTH];

  logic          accept;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [N:0]    a_ext;
  logic [N:0]    b_ext;
  logic [PW-1:0] prod;
  logic          wr_valid;
  logic [PW-1:0] wr_data;

  assign a_ext = {ext_op(in_a[N-1], in_signed), in_a};
  assign b_ext = {ext_op(in_b[N-1], in_signed), in_b};

  mult_core #(.N(N)) u_core (
    .a (a_ext),
    .b (b_ext),
    .p (prod)
  );

  assign accept     = in_valid & in_ready_q;
  assign pop        = out_valid & out_ready;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];
  assign in_ready   = in_ready_q;
  assign occupancy  = occ_q;

  generate
    if (LAT == 1) begin : g_no_stage
      assign wr_valid = accept;
      assign wr_data  = prod;
    end else begin : g_stage
      logic          stg_valid_q [LAT-1];
      logic          stg_valid_d [LAT-1];
      logic [PW-1:0] stg_data_q  [LAT-1];
      logic [PW-1:0] stg_data_d  [LAT-1];

      always_comb begin
        stg_valid_d[0] = accept;
        stg_data_d[0]  = prod;
        for (int j = 1; j < LAT - 1; j++) begin
          stg_valid_d[j] = stg_valid_q[j-1];
          stg_data_d[j]  = stg_data_q[j-1];
        end
      end

      always_ff @(posedge clk) begin
        for (int j = 0; j < LAT - 1; j++) begin
          if (rst) begin
            stg_valid_q[j] <= 1'b0;
            stg_data_q[j]  <= '0;
          end else begin
            stg_valid_q[j] <= stg_valid_d[j];
            stg_data_q[j]  <= stg_data_d[j];
          end
        end
      end

      assign wr_valid = stg_valid_q[LAT-2];
      assign wr_data  = stg_data_q[LAT-2];
    end
  endgenerate

  // Occupancy counts every beat from accept to pop, so it doubles as the input credit.
  always_comb begin
    state_d = (state_q == INIT) ? RUN : state_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    in_ready_d = (state_d == RUN) && (occ_d < CW'(DEPTH));
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_valid};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    last_d     = pop ? out_data : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      in_ready_q <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_q     <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_valid) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    occ_q <= CW'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_valid && fifo_full && !pop));

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_mult_stream_pipe.sv
// Directed and scoreboarded checks of mult_stream_pipe at N=16, LAT=3, DEPTH=4.
module tb_mult_stream_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  occupancy;

  int errors = 0;
  int checks = 0;

  mult_stream_pipe #(.N(16), .LAT(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b,
                                         input logic s);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sp;
    if (s) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      sp = sa * sb;
      return sp;
    end
    return {16'h0000, a} * {16'h0000, b};
  endfunction

  // Sends one beat, waits for its product and pops it; lat=-1 if it never appeared.
  task automatic run_beat(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [31:0] data, output int lat);
    int waits;
    out_ready = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_valid  = 1'b1;
    waits     = 0;
    while (!in_ready && waits < 20) begin
      tick();
      waits++;
    end
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    data = out_data;
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: in_ready=%b out_valid=%b out_data=%h, required 0/0/0",
                 i, in_ready, out_valid, out_data);
      end
    end
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL init_cycle: in_ready=%b, required 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || occupancy !== 3'd0) begin
      errors++;
      $display("[TB] FAIL run_entry: in_ready=%b occupancy=%0d, required 1/0", in_ready, occupancy);
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] data;
    int          lat;
    run_beat(16'hFFFF, 16'hFFFF, 1'b0, data, lat);
    checks++;
    if (data !== 32'hFFFE0001) begin
      errors++;
      $display("[TB] FAIL unsigned_max: got %h, required fffe0001", data);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("[TB] FAIL unsigned_latency: got %0d, required 3", lat);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'hFFFE0001) begin
      errors++;
      $display("[TB] FAIL empty_hold: out_valid=%b out_data=%h, required 0/fffe0001",
               out_valid, out_data);
    end
  endtask

  task automatic test_signed();
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic [31:0] te [3];
    logic [31:0] data;
    int          lat;
    ta = '{16'hFFFF, 16'h8000, 16'h8000};
    tb = '{16'hFFFF, 16'h0002, 16'h8000};
    te = '{32'h00000001, 32'hFFFF0000, 32'h40000000};
    for (int i = 0; i < 3; i++) begin
      run_beat(ta[i], tb[i], 1'b1, data, lat);
      checks++;
      if (data !== te[i]) begin
        errors++;
        $display("[TB] FAIL signed_%0d: %h*%h got %h, required %h", i, ta[i], tb[i], data, te[i]);
      end
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("[TB] FAIL signed_latency_%0d: got %0d, required 3", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ta [6];
    logic [15:0] tb [6];
    logic        ts [6];
    logic [31:0] te [4];
    int          idx;
    bit          acc;
    ta = '{16'h0003, 16'hFFFE, 16'h1234, 16'h7FFF, 16'h0101, 16'h0202};
    tb = '{16'h0005, 16'h0003, 16'h0010, 16'h8000, 16'h0101, 16'h0202};
    ts = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    te = '{32'h0000000F, 32'hFFFFFFFA, 32'h00012340, 32'hC0008000};
    idx       = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = ta[0];
    in_b      = tb[0];
    in_signed = ts[0];
    for (int c = 0; c < 6; c++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        idx++;
        in_a      = ta[idx];
        in_b      = tb[idx];
        in_signed = ts[idx];
      end
      if (c >= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000000F) begin
          errors++;
          $display("[TB] FAIL stall_stable: out_valid=%b out_data=%h, required 1/0000000f",
                   out_valid, out_data);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx !== 4 || in_ready !== 1'b0 || occupancy !== 3'd4) begin
      errors++;
      $display("[TB] FAIL credit_full: accepted=%0d in_ready=%b occupancy=%0d, required 4/0/4",
               idx, in_ready, occupancy);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== te[i]) begin
        errors++;
        $display("[TB] FAIL drain_%0d: out_valid=%b out_data=%h, required 1/%h",
                 i, out_valid, out_data, te[i]);
      end
      tick();
      if (i == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL credit_return: in_ready=%b, required 1", in_ready);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_data !== 32'hC0008000) begin
      errors++;
      $display("[TB] FAIL drained: out_valid=%b occupancy=%0d out_data=%h, required 0/0/c0008000",
               out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_reset_midflight();
    bit seen;
    out_ready = 1'b1;
    in_a      = 16'h0007;
    in_b      = 16'h0009;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_a = 16'h0011;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL flush: out_valid=%b occupancy=%0d in_ready=%b out_data=%h, required 0/0/0/0",
               out_valid, occupancy, in_ready, out_data);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_init: in_ready=%b, required 1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_ghost: out_valid seen=%b, required 0", seen);
    end
  endtask

  task automatic test_stream(input bit random_ready);
    logic [31:0] exp_q [$];
    logic [31:0] exp;
    int          sent;
    int          recv;
    int          stalls;
    int          cycles;
    bit          acc;
    sent      = 0;
    recv      = 0;
    stalls    = 0;
    cycles    = 0;
    in_a      = 16'($urandom());
    in_b      = 16'($urandom());
    in_signed = 1'($urandom_range(0, 1));
    in_valid  = 1'b1;
    out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    while ((sent < 200 || exp_q.size() != 0) && cycles < 3000) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL stream_extra: unexpected product %h", out_data);
        end else begin
          exp = exp_q.pop_front();
          recv++;
          if (out_data !== exp) begin
            errors++;
            $display("[TB] FAIL stream_data #%0d: got %h, required %h", recv, out_data, exp);
          end
        end
      end
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stalls++;
      if (acc) exp_q.push_back(golden(in_a, in_b, in_signed));
      tick();
      cycles++;
      if (acc) begin
        sent++;
        if (sent < 200) begin
          in_a      = 16'($urandom());
          in_b      = 16'($urandom());
          in_signed = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      if (random_ready) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv !== 200 || exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL stream_count: received %0d with %0d outstanding, required 200/0",
               recv, exp_q.size());
    end
    if (!random_ready) begin
      checks++;
      if (stalls !== 0) begin
        errors++;
        $display("[TB] FAIL stream_throughput: %0d stall cycles, required 0", stalls);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_midflight();
    test_stream(1'b0);
    test_stream(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
